regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file with write-to-read bypass, synchronous clear, and an integrated per-register busy scoreboard. It replaces the fixed 2-read/1-write, 32×32 file in the ID/WB stages of the RV32I pipeline. The scoreboard lets decode detect RAW hazards on registers whose producer is still in flight, so there is no separate hazard table.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 49 ++++
 rtl/regfile_mp.sv | 67 ++++++
 tb/tb_regfile_mp.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its
// busy scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int aw_of(input int nregs);
    return $clog2(nregs);
  endfunction

  // Low bit of port `port` inside a packed bus of `width`-bit lanes.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking in-flight producers, with per-read-port
// stall flags that account for same-cycle writeback forwarding.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  parameter int AW     = aw_of(NREGS_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] rs_addr,
  input  logic                reg_write,
  input  logic [AW-1:0]       rd,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic [NREAD-1:0]    rs_busy,
  output logic [NREGS-1:0]    busy_vec
);

  logic [NREGS-1:0] busy;

  // A new issue to the same register overrides a retiring writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (issue_valid && issue_rd == AW'(r))
          busy[r] <= 1'b1;
        else if (reg_write && rd == AW'(r))
          busy[r] <= 1'b0;
      end
    end
  end

  assign busy_vec = rst ? '0 : busy;

  for (genvar k = 0; k < NREAD; k++) begin : g_port
    logic [AW-1:0] a;
    logic          fwd;
    assign a   = rs_addr[slice_lo(k, AW) +: AW];
    assign fwd = (BYPASS != 0) && reg_write && (rd == a);
    assign rs_busy[k] = !rst && busy[a] && !fwd;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file with write-to-read
// bypass, synchronous clear and an integrated busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = aw_of(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic                  reg_write,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       wd,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic [NREGS-1:0]      busy_vec
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (reg_write && rd != '0) begin
      regs[rd] <= wd;
    end
  end

  // Read path: x0 is constant zero; a same-cycle writeback wins over storage.
  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [AW-1:0]   a;
    logic [XLEN-1:0] data;
    assign a = rs_addr[slice_lo(k, AW) +: AW];
    always_comb begin
      data = regs[a];
      if (rst || a == '0)
        data = '0;
      else if ((BYPASS != 0) && reg_write && rd == a)
        data = wd;
    end
    assign rs_data[slice_lo(k, XLEN) +: XLEN] = data;
  end

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rs_addr     (rs_addr),
    .reg_write   (reg_write),
    .rd          (rd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs_busy     (rs_busy),
    .busy_vec    (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and non-bypass 32x32 instances against an
// array model, plus a 16x64 three-port instance for slicing.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  rs_addr;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [63:0] data_b, data_n;
  logic [1:0]  busy_b, busy_n;
  logic [31:0] vec_b, vec_n;

  logic         p_rst;
  logic [11:0]  p_addr;
  logic         p_we;
  logic [3:0]   p_rd;
  logic [63:0]  p_wd;
  logic         p_iv;
  logic [3:0]   p_ird;
  logic [191:0] p_data;
  logic [2:0]   p_busy;
  logic [15:0]  p_vec;

  int checks = 0;
  int errors = 0;

  logic [31:0] mregs [32];
  logic        mbusy [32];

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(data_b), .rs_busy(busy_b),
    .reg_write(reg_write), .rd(rd), .wd(wd), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .busy_vec(vec_b));

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(data_n), .rs_busy(busy_n),
    .reg_write(reg_write), .rd(rd), .wd(wd), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .busy_vec(vec_n));

  regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(1)) dut_p (
    .clk(clk), .rst(p_rst), .rs_addr(p_addr), .rs_data(p_data), .rs_busy(p_busy),
    .reg_write(p_we), .rd(p_rd), .wd(p_wd), .issue_valid(p_iv),
    .issue_rd(p_ird), .busy_vec(p_vec));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (rst || a == 5'd0) return 32'd0;
    if (byp && reg_write && rd == a) return wd;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (rst) return 1'b0;
    return mbusy[a] && !(byp && reg_write && rd == a);
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < 32; r++) v[r] = mbusy[r];
    return rst ? 32'd0 : v;
  endfunction

  task automatic check_all();
    logic [4:0] a;
    for (int k = 0; k < 2; k++) begin
      a = rs_addr[k*5 +: 5];
      chk($sformatf("data_byp[%0d] a=%0d", k, a), {32'd0, data_b[k*32 +: 32]}, {32'd0, exp_data(a, 1'b1)});
      chk($sformatf("data_nobyp[%0d] a=%0d", k, a), {32'd0, data_n[k*32 +: 32]}, {32'd0, exp_data(a, 1'b0)});
      chk($sformatf("busy_byp[%0d] a=%0d", k, a), {63'd0, busy_b[k]}, {63'd0, exp_busy(a, 1'b1)});
      chk($sformatf("busy_nobyp[%0d] a=%0d", k, a), {63'd0, busy_n[k]}, {63'd0, exp_busy(a, 1'b0)});
    end
    chk("busy_vec_byp", {32'd0, vec_b}, {32'd0, exp_vec()});
    chk("busy_vec_nobyp", {32'd0, vec_n}, {32'd0, exp_vec()});
  endtask

  // One clock: drive, check combinational outputs, then advance the model.
  task automatic cyc(input logic r, input logic [9:0] ra, input logic we,
                     input logic [4:0] rdi, input logic [31:0] wdi,
                     input logic iv, input logic [4:0] ir);
    rst = r; rs_addr = ra; reg_write = we; rd = rdi; wd = wdi;
    issue_valid = iv; issue_rd = ir;
    #1 check_all();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
    end else begin
      if (reg_write && rd != 5'd0) mregs[rd] = wd;
      if (reg_write) mbusy[rd] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) mbusy[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
    rst = 1'b1; rs_addr = '0; reg_write = 1'b0; rd = '0; wd = '0;
    issue_valid = 1'b0; issue_rd = '0;
    p_rst = 1'b1; p_addr = '0; p_we = 1'b0; p_rd = '0; p_wd = '0; p_iv = 1'b0; p_ird = '0;
    @(negedge clk);

    // Reset with write/issue activity that must be dropped and masked.
    cyc(1, {5'd7, 5'd7}, 1, 5'd7, 32'h55, 1, 5'd7);
    cyc(1, {5'd7, 5'd7}, 1, 5'd7, 32'h55, 1, 5'd7);
    // Preload x5 and mark it busy, then reset once.
    cyc(0, {5'd5, 5'd5}, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5);
    cyc(0, {5'd5, 5'd5}, 0, 5'd0, 32'd0, 0, 5'd0);
    cyc(1, {5'd5, 5'd5}, 1, 5'd5, 32'h1111, 1, 5'd6);
    cyc(0, {5'd5, 5'd5}, 0, 5'd0, 32'd0, 0, 5'd0);
    // x0 write and issue are ignored.
    cyc(0, {5'd0, 5'd0}, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0);
    cyc(0, {5'd0, 5'd0}, 0, 5'd0, 32'd0, 0, 5'd0);
    // Same-cycle forwarding on both ports.
    cyc(0, {5'd7, 5'd7}, 1, 5'd7, 32'h1234, 0, 5'd0);
    cyc(0, {5'd7, 5'd7}, 0, 5'd0, 32'd0, 0, 5'd0);
    // Issue x3, writeback three cycles later.
    cyc(0, {5'd3, 5'd3}, 0, 5'd0, 32'd0, 1, 5'd3);
    repeat (3) cyc(0, {5'd3, 5'd3}, 0, 5'd0, 32'd0, 0, 5'd0);
    cyc(0, {5'd3, 5'd3}, 1, 5'd3, 32'hABC, 0, 5'd0);
    cyc(0, {5'd3, 5'd3}, 0, 5'd0, 32'd0, 0, 5'd0);
    // Set and clear of x9 in the same cycle.
    cyc(0, {5'd9, 5'd9}, 0, 5'd0, 32'd0, 1, 5'd9);
    cyc(0, {5'd9, 5'd9}, 1, 5'd9, 32'h99, 1, 5'd9);
    cyc(0, {5'd9, 5'd9}, 0, 5'd0, 32'd0, 0, 5'd0);

    repeat (400)
      cyc(($urandom_range(0, 39) == 0), 10'($urandom), 1'($urandom), 5'($urandom),
          $urandom, 1'($urandom), 5'($urandom));

    // 16 x 64, three read ports.
    p_rst = 1'b0;
    p_addr = {4'd15, 4'd15, 4'd15};
    p_we = 1'b1; p_rd = 4'd15; p_wd = 64'hA5A5_0000_0000_5A5A;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("p_fwd[%0d]", k), p_data[k*64 +: 64], 64'hA5A5_0000_0000_5A5A);
    @(posedge clk); @(negedge clk);
    p_we = 1'b0; p_rd = 4'd0; p_wd = '0; p_iv = 1'b1; p_ird = 4'd15;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("p_stored[%0d]", k), p_data[k*64 +: 64], 64'hA5A5_0000_0000_5A5A);
    chk("p_vec_idle", {48'd0, p_vec}, 64'd0);
    @(posedge clk); @(negedge clk);
    p_iv = 1'b0; p_ird = 4'd0;
    p_addr = {4'd0, 4'd15, 4'd3};
    #1;
    chk("p_port0_x3", p_data[63:0], 64'd0);
    chk("p_port1_x15", p_data[127:64], 64'hA5A5_0000_0000_5A5A);
    chk("p_port2_x0", p_data[191:128], 64'd0);
    chk("p_busy", {61'd0, p_busy}, 64'd2);
    chk("p_vec_x15", {48'd0, p_vec}, 64'h8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
